zbus_host: RTL and testbench
============================

# zbus_host

Synchronous ZX-bus initiator that turns single-beat read/write commands into Z80-shaped I/O and memory bus cycles on za/zd/ziorq_n/zmreq_n/zrd_n/zwr_n. Every control strobe is a registered output. It is the driving end of the bus that our peripheral card responds to. It sits in the FPGA bench/host harness, taking commands from a processor or test sequencer. It also drives a stretched bus reset and synchronises the card's open-drain zint_n.

## Interface
Parameters:
- TSTATE_CLKS, 4: clk cycles per Z80 T-state (N). Even, ≥2. H = N/2.
- IO_WAITS, 1: TW states inserted in I/O cycles, range 0..3.
- RST_CLKS, 16: clocks zrst_n stays low after rst deasserts, ≥1.

Ports:
- clk in 1: single clock.
- rst in 1: synchronous, active-high reset.
- cmd_valid in 1: command request.
- cmd_ready out 1: block idle; command accepted on the clk where valid&ready.
- cmd_write in 1: 1 write, 0 read.
- cmd_io in 1: 1 I/O cycle, 0 memory cycle.
- cmd_addr in 16: bus address.
- cmd_wdata in 8: write data.
- rsp_valid out 1: one-clk pulse at cycle end, for reads and writes.
- rsp_rdata out 8: zd_in sampled at the sample point; 0x00 for writes.
- rsp_claimed out 1: ziorqge sampled at the sample point, I/O cycles only, else 0.
- za out 16; zd_out out 8; zd_oe out 1: data bus drive.
- zd_in in 8: bus read data.
- ziorq_n, zmreq_n, zrd_n, zwr_n out 1 each: registered bus strobes.
- ziorqge in 1; zint_n in 1: asynchronous inputs.
- zrst_n out 1: bus reset.
- int_level out 1: synchronised ~zint_n.
- int_rise out 1: one-clk pulse on int_level 0→1.

## Operation
- States: RSTHOLD, IDLE, T1, T2, TW, T3. A tick counter runs 0..N-1 in each T-state. A wait counter counts TW states.
- RSTHOLD: entered on rst. zrst_n=0, cmd_ready=0. Exits to IDLE after RST_CLKS clks with rst low.
- IDLE: cmd_ready=1. On accept, latch addr/data/type; go to T1 on the next clk.
- I/O sequence: T1 → T2 → TW×IO_WAITS → T3 → IDLE.
  - za valid from T1 start.
  - ziorq_n plus zrd_n or zwr_n low from T2 tick 0 through the last tick of T3.
  - For writes, zd_oe=1 from T1 through end of T3.
- Memory sequence: T1 → T2 → T3 → IDLE, no TW.
  - Read: zmreq_n and zrd_n low from T1 tick H through T3 tick H-1.
  - Write: zmreq_n low from T1 tick H; zwr_n low from T2 tick 0; both high from T3 tick H. zd_oe=1 from T1 tick H through end of T3.
- Sample point: the last clk on which the read strobe is low. The registered zd_in and ziorqge are the values that clk sees.
- rsp_valid pulses on the first IDLE clk. cmd_ready is 1 on that same clk, so a back-to-back accept is legal.
- cmd_* inputs are ignored outside IDLE. Outputs are unaffected by cmd_* changes during a cycle.
- Interrupt path: 2-flop synchroniser on zint_n, then edge detect. The path is independent of the cycle FSM.

## Timing
- Reset values (rst high): state RSTHOLD, all strobes 1, za=0, zd_out=0, zd_oe=0, zrst_n=0, cmd_ready=0, rsp_valid=0, rsp_rdata=0, rsp_claimed=0, int_level=0, int_rise=0.
- rst mid-cycle: on the next clk all strobes go to 1 and zd_oe to 0, with no rsp_valid. The RSTHOLD stretch restarts.
- Latency from the accept clk k:
  - I/O: rsp_valid at k+(3+IO_WAITS)·N+1.
  - Memory: rsp_valid at k+3N+1.
- Strobe low widths:
  - I/O: (2+IO_WAITS)·N clks.
  - Memory read: 2N clks.
  - Memory write: zwr_n low N+H clks.
- za and zd_out are stable for the whole cycle. No glitches: each strobe changes at most twice per cycle.
- int_level lags zint_n by 2–3 clks.

## Structure
- zbus_pkg: FSM state enum, cycle-type constants (CYC_IO, CYC_MEM), default parameter constants.
- Sub-module zbus_int_sync: synchroniser and rise detector. Reused wherever the card's asynchronous inputs enter a clocked domain.

## Test plan
- Reset: hold rst for 3 clks, RST_CLKS=16 → zrst_n low until 16 clks after rst falls; cmd_ready rises on the same clk zrst_n rises; strobes stay 1 throughout.
- I/O read at N=4, IO_WAITS=1: addr 0x00AB, zd_in=0x5A, ziorqge=1 → ziorq_n/zrd_n low for 12 clks, za=0x00AB; rsp at k+17 with rdata=0x5A, claimed=1.
- I/O write: addr 0x80AB, data 0xC3 → zd_oe=1 for 16 clks with zd_out=0xC3, zwr_n low for 12 clks; rsp at k+17 with rdata=0x00.
- Memory read, then a back-to-back memory write (accepted on the rsp clk): addr 0x3FFF read 0x77, then write 0x11 → read strobes low 8 clks, rdata=0x77; zwr_n low 6 clks; no IDLE gap between the two cycles.
- rst asserted at T2 tick 1 of an I/O read → all strobes 1 and zd_oe=0 next clk; no rsp_valid; RSTHOLD repeats.
- zint_n driven low at an arbitrary phase during an active cycle → int_rise pulses once within 3 clks; int_level=1 until zint_n releases; the bus cycle is unaffected.

Source files
------------

// File: rtl/zbus_pkg.sv
// zbus_pkg: shared types and constants for the ZX-bus host.
//   zbus_state_e  - bus-cycle FSM states
//   CYC_IO/MEM    - values of the latched cycle-type bit
//   DEF_*         - default parameter values for zbus_host
//   zbus_strb_t   - bundle of registered bus strobes + data drive enable
//   strb_decode   - strobe levels for a given (state, half-T-state, type)
package zbus_pkg;

  typedef enum logic [2:0] {
    ST_RSTHOLD,
    ST_IDLE,
    ST_T1,
    ST_T2,
    ST_TW,
    ST_T3
  } zbus_state_e;

  localparam logic CYC_IO  = 1'b1;
  localparam logic CYC_MEM = 1'b0;

  localparam int DEF_TSTATE_CLKS = 4;
  localparam int DEF_IO_WAITS    = 1;
  localparam int DEF_RST_CLKS    = 16;

  typedef struct packed {
    logic ziorq_n;
    logic zmreq_n;
    logic zrd_n;
    logic zwr_n;
    logic zd_oe;
  } zbus_strb_t;

  // lo_half: tick is in the first half of the T-state (tick < N/2).
  // I/O cycles assert over whole T-states; memory cycles start and end
  // on the half T-state, mirroring Z80 MREQ/RD/WR placement.
  function automatic zbus_strb_t strb_decode(input zbus_state_e st,
                                             input logic lo_half,
                                             input logic io,
                                             input logic wr);
    zbus_strb_t s;
    logic busy, mreq, wstb;
    s.ziorq_n = 1'b1;
    s.zmreq_n = 1'b1;
    s.zrd_n   = 1'b1;
    s.zwr_n   = 1'b1;
    s.zd_oe   = 1'b0;
    busy = 1'b0;
    mreq = 1'b0;
    wstb = 1'b0;
    if (io == CYC_IO) begin
      busy      = (st == ST_T2) || (st == ST_TW) || (st == ST_T3);
      s.ziorq_n = !busy;
      s.zrd_n   = !(busy && !wr);
      s.zwr_n   = !(busy && wr);
      s.zd_oe   = wr && ((st == ST_T1) || busy);
    end else begin
      mreq      = ((st == ST_T1) && !lo_half) || (st == ST_T2) ||
                  ((st == ST_T3) && lo_half);
      wstb      = (st == ST_T2) || ((st == ST_T3) && lo_half);
      s.zmreq_n = !mreq;
      s.zrd_n   = !(mreq && !wr);
      s.zwr_n   = !(wstb && wr);
      s.zd_oe   = wr && (((st == ST_T1) && !lo_half) || (st == ST_T2) ||
                         (st == ST_T3));
    end
    return s;
  endfunction

endpackage

// File: rtl/zbus_int_sync.sv
// zbus_int_sync: brings an asynchronous card signal into the clk domain.
//   clk, rst   - clock, synchronous active-high reset
//   async_in   - raw asynchronous input
//   level      - synchronised, polarity-corrected level (registered)
//   rise       - one-clk pulse when level goes 0->1 (registered)
// ACTIVE_LOW=1 inverts the input so level=1 means "asserted".
module zbus_int_sync #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic s1, s2;

  // s1/s2 form the two-flop synchroniser; level is the edge-detect
  // history flop and doubles as the registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      s1    <= async_in ^ ACTIVE_LOW;
      s2    <= s1;
      level <= s2;
      rise  <= s2 & ~level;
    end
  end

endmodule

// File: rtl/zbus_host.sv
// zbus_host: ZX-bus initiator. Converts single-beat commands into
// Z80-shaped I/O and memory cycles with registered strobes, stretches
// bus reset and synchronises the card interrupt.
//   clk, rst                 - clock, synchronous active-high reset
//   cmd_valid/ready          - command handshake (accepted in IDLE)
//   cmd_write/io/addr/wdata  - command fields
//   rsp_valid/rdata/claimed  - one-clk response at cycle end
//   za, zd_out, zd_oe, zd_in - address / data bus
//   ziorq_n..zwr_n           - bus strobes
//   ziorqge                  - card I/O claim (sampled at sample point)
//   zint_n                   - card interrupt, open-drain, async
//   zrst_n                   - stretched bus reset
//   int_level, int_rise      - synchronised interrupt and its rise pulse
module zbus_host
  import zbus_pkg::*;
#(
  parameter int TSTATE_CLKS = DEF_TSTATE_CLKS,
  parameter int IO_WAITS    = DEF_IO_WAITS,
  parameter int RST_CLKS    = DEF_RST_CLKS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic        cmd_io,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_claimed,
  output logic [15:0] za,
  output logic [7:0]  zd_out,
  output logic        zd_oe,
  input  logic [7:0]  zd_in,
  output logic        ziorq_n,
  output logic        zmreq_n,
  output logic        zrd_n,
  output logic        zwr_n,
  input  logic        ziorqge,
  input  logic        zint_n,
  output logic        zrst_n,
  output logic        int_level,
  output logic        int_rise
);

  localparam int TW = (TSTATE_CLKS > 2) ? $clog2(TSTATE_CLKS) : 1;
  localparam int RW = $clog2(RST_CLKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TSTATE_CLKS - 1);
  localparam logic [TW-1:0] TICK_H    = TW'(TSTATE_CLKS / 2);
  localparam logic [TW-1:0] TICK_HM1  = TW'(TSTATE_CLKS / 2 - 1);
  localparam logic [RW-1:0] RCNT_LAST = RW'(RST_CLKS - 1);
  localparam logic [1:0]    WAIT_LAST = 2'(IO_WAITS - 1);
  localparam bit            HAS_WAITS = (IO_WAITS > 0);

  zbus_state_e   state, st_n;
  logic [TW-1:0] tick, tick_n;
  logic [1:0]    wcnt, wcnt_n;
  logic [RW-1:0] rcnt, rcnt_n;
  logic          cyc_io, cyc_write;
  logic          accept, end_cyc, sample;
  logic          nxt_io, nxt_wr;
  zbus_strb_t    strb_n;

  // Next-state decode. Strobes are computed from the *next* state so the
  // registered outputs line up exactly with the registered state.
  always_comb begin
    st_n    = state;
    tick_n  = tick;
    wcnt_n  = wcnt;
    rcnt_n  = rcnt;
    end_cyc = 1'b0;
    accept  = cmd_valid && cmd_ready;
    case (state)
      ST_RSTHOLD: begin
        if (rcnt == RCNT_LAST) st_n = ST_IDLE;
        else                   rcnt_n = rcnt + 1'b1;
      end
      ST_IDLE: begin
        if (accept) begin
          st_n   = ST_T1;
          tick_n = '0;
        end
      end
      default: begin
        if (tick != TICK_LAST) begin
          tick_n = tick + 1'b1;
        end else begin
          tick_n = '0;
          case (state)
            ST_T1: st_n = ST_T2;
            ST_T2: begin
              if (cyc_io && HAS_WAITS) begin
                st_n   = ST_TW;
                wcnt_n = '0;
              end else begin
                st_n = ST_T3;
              end
            end
            ST_TW: begin
              if (wcnt == WAIT_LAST) st_n = ST_T3;
              else                   wcnt_n = wcnt + 1'b1;
            end
            ST_T3: begin
              st_n    = ST_IDLE;
              end_cyc = 1'b1;
            end
            default: st_n = ST_IDLE;
          endcase
        end
      end
    endcase
    // A back-to-back accept must decode T1 with the new command's type.
    nxt_io = accept ? cmd_io    : cyc_io;
    nxt_wr = accept ? cmd_write : cyc_write;
    strb_n = strb_decode(st_n, (tick_n < TICK_H), nxt_io, nxt_wr);
    // Last clk with the read strobe low: end of T3 for I/O, mid-T3 for memory.
    sample = (state == ST_T3) && (tick == (cyc_io ? TICK_LAST : TICK_HM1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_RSTHOLD;
      tick        <= '0;
      wcnt        <= '0;
      rcnt        <= '0;
      cyc_io      <= CYC_MEM;
      cyc_write   <= 1'b0;
      za          <= '0;
      zd_out      <= '0;
      zd_oe       <= 1'b0;
      ziorq_n     <= 1'b1;
      zmreq_n     <= 1'b1;
      zrd_n       <= 1'b1;
      zwr_n       <= 1'b1;
      zrst_n      <= 1'b0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_claimed <= 1'b0;
    end else begin
      state <= st_n;
      tick  <= tick_n;
      wcnt  <= wcnt_n;
      rcnt  <= rcnt_n;
      if (accept) begin
        cyc_io    <= cmd_io;
        cyc_write <= cmd_write;
        za        <= cmd_addr;
        zd_out    <= cmd_wdata;
      end
      ziorq_n   <= strb_n.ziorq_n;
      zmreq_n   <= strb_n.zmreq_n;
      zrd_n     <= strb_n.zrd_n;
      zwr_n     <= strb_n.zwr_n;
      zd_oe     <= strb_n.zd_oe;
      zrst_n    <= (st_n != ST_RSTHOLD);
      cmd_ready <= (st_n == ST_IDLE);
      rsp_valid <= end_cyc;
      // ziorqge is qualified by the strobes and held by the card, so it is
      // captured directly rather than through a multi-clk synchroniser.
      if (sample) begin
        rsp_rdata   <= cyc_write ? 8'h00 : zd_in;
        rsp_claimed <= cyc_io & ziorqge;
      end
    end
  end

  zbus_int_sync #(.ACTIVE_LOW(1'b1)) u_int_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (zint_n),
    .level    (int_level),
    .rise     (int_rise)
  );

endmodule

// File: tb/tb_zbus_host.sv
module tb_zbus_host;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0, cmd_ready;
  logic        cmd_write = 1'b0, cmd_io = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [7:0]  cmd_wdata = '0;
  logic        rsp_valid, rsp_claimed;
  logic [7:0]  rsp_rdata;
  logic [15:0] za;
  logic [7:0]  zd_out, zd_in = '0;
  logic        zd_oe, ziorq_n, zmreq_n, zrd_n, zwr_n;
  logic        ziorqge = 1'b0, zint_n = 1'b1;
  logic        zrst_n, int_level, int_rise;

  zbus_host #(.TSTATE_CLKS(4), .IO_WAITS(1), .RST_CLKS(16)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_io(cmd_io), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_claimed(rsp_claimed), .za(za), .zd_out(zd_out), .zd_oe(zd_oe),
    .zd_in(zd_in), .ziorq_n(ziorq_n), .zmreq_n(zmreq_n), .zrd_n(zrd_n),
    .zwr_n(zwr_n), .ziorqge(ziorqge), .zint_n(zint_n), .zrst_n(zrst_n),
    .int_level(int_level), .int_rise(int_rise)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  rdata;
    logic        claimed;
    int          due;
    int          iorq_w, mreq_w, rd_w, wr_w, oe_w;
    logic [15:0] addr;
    logic [7:0]  wd;
  } exp_t;

  exp_t q[$];
  int   errors = 0, checks = 0;
  int   cyc = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] rd, input logic cl, input int lat,
                              input int iw, input int mw, input int rw, input int ww,
                              input int ow, input logic [15:0] a, input logic [7:0] wd);
    exp_t e;
    e.rdata = rd; e.claimed = cl; e.due = lat;
    e.iorq_w = iw; e.mreq_w = mw; e.rd_w = rw; e.wr_w = ww; e.oe_w = ow;
    e.addr = a; e.wd = wd;
    return e;
  endfunction

  // Monitor: accumulates per-cycle strobe widths and bus stability, and
  // compares against the scoreboard head whenever rsp_valid is seen.
  initial begin
    int c_iorq, c_mreq, c_rd, c_wr, c_oe, za_bad, zd_bad;
    exp_t e;
    c_iorq = 0; c_mreq = 0; c_rd = 0; c_wr = 0; c_oe = 0; za_bad = 0; zd_bad = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        c_iorq = 0; c_mreq = 0; c_rd = 0; c_wr = 0; c_oe = 0; za_bad = 0; zd_bad = 0;
      end else begin
        if (!ziorq_n) c_iorq++;
        if (!zmreq_n) c_mreq++;
        if (!zrd_n)   c_rd++;
        if (!zwr_n)   c_wr++;
        if (zd_oe)    c_oe++;
        if (q.size() > 0) begin
          if (!(ziorq_n && zmreq_n && zrd_n && zwr_n) && za !== q[0].addr) za_bad++;
          if (zd_oe && zd_out !== q[0].wd) zd_bad++;
        end
        if (rsp_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_rsp", 32'd1, 32'd0);
          end else begin
            e = q.pop_front();
            chk("rsp_rdata",   32'(rsp_rdata), 32'(e.rdata));
            chk("rsp_claimed", 32'(rsp_claimed), 32'(e.claimed));
            chk("rsp_latency", 32'(cyc), 32'(e.due));
            chk("iorq_width",  32'(c_iorq), 32'(e.iorq_w));
            chk("mreq_width",  32'(c_mreq), 32'(e.mreq_w));
            chk("rd_width",    32'(c_rd), 32'(e.rd_w));
            chk("wr_width",    32'(c_wr), 32'(e.wr_w));
            chk("oe_width",    32'(c_oe), 32'(e.oe_w));
            chk("za_stable",   32'(za_bad), 32'd0);
            chk("zd_stable",   32'(zd_bad), 32'd0);
          end
          c_iorq = 0; c_mreq = 0; c_rd = 0; c_wr = 0; c_oe = 0; za_bad = 0; zd_bad = 0;
        end
      end
    end
  end

  // Present a command, wait (bounded) for accept, optionally push expectation.
  // e.due holds the latency on entry; it becomes an absolute clk index here.
  task automatic issue(input logic wr, input logic io, input logic [15:0] a,
                       input logic [7:0] wd, input exp_t e, input bit push,
                       output int acc);
    int n;
    @(negedge clk);
    cmd_write = wr; cmd_io = io; cmd_addr = a; cmd_wdata = wd; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) chk("accept_timeout", 32'd1, 32'd0);
    acc = cyc;
    e.due = acc + e.due;
    if (push) q.push_back(e);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    // Scramble the command bus: the cycle in flight must not follow it.
    cmd_addr = 16'hFFFF; cmd_wdata = 8'hEE; cmd_write = ~wr; cmd_io = ~io;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  // Called at a negedge right after rst drops: zrst_n must stay low for
  // RST_CLKS clks counting the release clk, and cmd_ready rise with it.
  task automatic rst_stretch(input string nm);
    int n, bad;
    n = 0; bad = 0;
    while (!zrst_n && n < 40) begin
      if (cmd_ready) bad++;
      if ({ziorq_n, zmreq_n, zrd_n, zwr_n} != 4'hF || zd_oe) bad++;
      n++;
      @(negedge clk);
    end
    chk({nm, "_zrst_len"}, 32'(n), 32'd16);
    chk({nm, "_ready"}, 32'(cmd_ready), 32'd1);
    chk({nm, "_hold_quiet"}, 32'(bad), 32'd0);
  endtask

  initial begin
    int acc, acc2, first, rises, lows, n;

    // Reset values after 3 clks of rst.
    repeat (3) @(negedge clk);
    chk("rst_strobes", 32'({ziorq_n, zmreq_n, zrd_n, zwr_n}), 32'hF);
    chk("rst_za", 32'(za), 32'd0);
    chk("rst_zd_out", 32'(zd_out), 32'd0);
    chk("rst_zd_oe", 32'(zd_oe), 32'd0);
    chk("rst_zrst_n", 32'(zrst_n), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_rsp", 32'({rsp_valid, rsp_claimed, rsp_rdata}), 32'd0);
    chk("rst_int", 32'({int_level, int_rise}), 32'd0);
    rst = 1'b0;
    rst_stretch("init");

    // I/O read 0x00AB, card drives 0x5A and claims.
    zd_in = 8'h5A; ziorqge = 1'b1;
    issue(1'b0, 1'b1, 16'h00AB, 8'h00, mk(8'h5A, 1'b1, 17, 12, 0, 12, 0, 0, 16'h00AB, 8'h00), 1'b1, acc);
    drain();

    // I/O write 0x80AB <- 0xC3.
    ziorqge = 1'b0;
    issue(1'b1, 1'b1, 16'h80AB, 8'hC3, mk(8'h00, 1'b0, 17, 12, 0, 0, 12, 16, 16'h80AB, 8'hC3), 1'b1, acc);
    drain();

    // Memory read 0x3FFF, then write accepted on the read's rsp clk.
    zd_in = 8'h77; ziorqge = 1'b1;
    issue(1'b0, 1'b0, 16'h3FFF, 8'h00, mk(8'h77, 1'b0, 13, 0, 8, 8, 0, 0, 16'h3FFF, 8'h00), 1'b1, acc);
    issue(1'b1, 1'b0, 16'h4000, 8'h11, mk(8'h00, 1'b0, 13, 0, 8, 0, 6, 10, 16'h4000, 8'h11), 1'b1, acc2);
    chk("b2b_accept", 32'(acc2), 32'(acc + 13));
    drain();

    // Interrupt asserted mid-phase during an I/O read.
    zd_in = 8'h12; ziorqge = 1'b0;
    issue(1'b0, 1'b1, 16'h0012, 8'h00, mk(8'h12, 1'b0, 17, 12, 0, 12, 0, 0, 16'h0012, 8'h00), 1'b1, acc);
    @(negedge clk);
    #3 zint_n = 1'b0;
    rises = 0; first = -1;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (int_rise) rises++;
      if (int_level && first < 0) first = i;
    end
    chk("int_rise_count", 32'(rises), 32'd1);
    chk("int_level_lag", 32'(first), 32'd3);
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!int_level || int_rise) lows++;
    end
    chk("int_level_hold", 32'(lows), 32'd0);
    zint_n = 1'b1;
    n = 0;
    while (int_level && n < 6) begin
      @(negedge clk);
      n++;
    end
    chk("int_release", 32'(int_level), 32'd0);
    drain();

    // rst at T2 tick 1 of an I/O read: strobes drop next clk, no response.
    zd_in = 8'h99; ziorqge = 1'b1;
    issue(1'b0, 1'b1, 16'h0055, 8'h00, mk(8'h99, 1'b1, 17, 12, 0, 12, 0, 0, 16'h0055, 8'h00), 1'b0, acc);
    n = 0;
    while (cyc != acc + 6 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("abort_t2_active", 32'({ziorq_n, zrd_n}), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_strobes", 32'({ziorq_n, zmreq_n, zrd_n, zwr_n}), 32'hF);
    chk("abort_oe", 32'(zd_oe), 32'd0);
    chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
    chk("abort_zrst_n", 32'(zrst_n), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    rst_stretch("abort");
    repeat (20) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
